// File: rtl/citadel_uart_if.sv
// Core-side byte port of citadel_uart: TX push handshake and RX pop handshake.
interface citadel_uart_if;
  logic [7:0] tx_data;
  logic       tx_strobe;
  logic       tx_full;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;

  modport master (output tx_data, tx_strobe, rx_ack,
                  input  tx_full, rx_data, rx_valid);
  modport slave  (input  tx_data, tx_strobe, rx_ack,
                  output tx_full, rx_data, rx_valid);
endinterface

// File: rtl/citadel_uart.sv
// 8N1 UART with TX and RX byte FIFOs between the Citadel core byte port
// and the serial pins. TX output is registered one cycle behind the TX FSM.
module citadel_uart #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic          r_clk,
  input  logic          rst_n,
  citadel_uart_if.slave bus,
  output logic          uart_txd,
  input  logic          uart_rxd,
  output logic          rx_overrun,
  output logic          frame_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [PW:0]   DEPTH_C  = FIFO_DEPTH[PW:0];
  localparam logic [CW-1:0] CPB_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CPB_FULL = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] CPB_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] TICK_ONE = CW'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  // TX side state
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PW:0]   tx_cnt_q, tx_cnt_d;
  logic          tx_full_q, tx_full_d;
  logic          tx_push, tx_pop;
  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_tick_q, tx_tick_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          txd_q, txd_d;

  // RX side state
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [PW:0]   rx_cnt_q, rx_cnt_d;
  logic          rx_push, rx_pop, rx_full, rx_wr_en;
  logic          rxd_meta_q, rxd_sync_q;
  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_tick_q, rx_tick_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          overrun_q, overrun_d, frame_err_q, frame_err_d;

  // TX FSM next state; pops the FIFO head from IDLE or straight out of STOP
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_cnt_q != '0) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_mem[tx_rd_q];
          tx_tick_d  = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_tick_q == CPB_LAST) begin
          tx_tick_d  = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_tick_d = tx_tick_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_tick_q == CPB_LAST) begin
          tx_tick_d  = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          else                  tx_bit_d   = tx_bit_q + 1'b1;
        end else begin
          tx_tick_d = tx_tick_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_tick_q == CPB_LAST) begin
          tx_tick_d = '0;
          if (tx_cnt_q != '0) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_mem[tx_rd_q];
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_tick_d = tx_tick_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    case (tx_state_q)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_q[0];
      default:  txd_d = 1'b1;
    endcase
  end

  // TX FIFO bookkeeping; a push while full is silently dropped
  always_comb begin
    tx_push   = bus.tx_strobe && !tx_full_q;
    tx_wr_d   = tx_wr_q + PW'(tx_push);
    tx_rd_d   = tx_rd_q + PW'(tx_pop);
    tx_cnt_d  = tx_cnt_q + (PW+1)'(tx_push) - (PW+1)'(tx_pop);
    tx_full_d = (tx_cnt_d == DEPTH_C);
  end

  // TX FIFO storage write port
  always_ff @(posedge r_clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= bus.tx_data;
  end

  // TX registers; reset forces the line high even mid-frame
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_cnt_q   <= '0;
      tx_full_q  <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_full_q  <= tx_full_d;
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  // RX FSM next state; the tick counter counts down and fires at 1,
  // so the first fire lands mid start bit and later fires one bit apart
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_tick_d   = rx_tick_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    frame_err_d = frame_err_q;
    rx_push     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rxd_sync_q) begin
          rx_tick_d  = CPB_HALF;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_tick_q == TICK_ONE) begin
          if (rxd_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_tick_d  = CPB_FULL;
            rx_bit_d   = '0;
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_tick_d = rx_tick_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_tick_q == TICK_ONE) begin
          rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
          rx_tick_d  = CPB_FULL;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_tick_d = rx_tick_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_tick_q == TICK_ONE) begin
          if (rxd_sync_q) begin
            rx_push    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            rx_state_d  = RX_WAIT_HIGH;
          end
        end else begin
          rx_tick_d = rx_tick_q - 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (rxd_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX FIFO bookkeeping; a simultaneous pop frees the slot for a push when full
  always_comb begin
    rx_pop    = bus.rx_ack && (rx_cnt_q != '0);
    rx_full   = (rx_cnt_q == DEPTH_C);
    rx_wr_en  = rx_push && (!rx_full || rx_pop);
    rx_wr_d   = rx_wr_q + PW'(rx_wr_en);
    rx_rd_d   = rx_rd_q + PW'(rx_pop);
    rx_cnt_d  = rx_cnt_q + (PW+1)'(rx_wr_en) - (PW+1)'(rx_pop);
    overrun_d = overrun_q || (rx_push && rx_full && !rx_pop);
  end

  // RX FIFO storage write port
  always_ff @(posedge r_clk) begin
    if (rx_wr_en) rx_mem[rx_wr_q] <= rx_shift_q;
  end

  // RX registers, including the two-flop synchronizer that idles high
  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      rx_cnt_q    <= '0;
      rx_state_q  <= RX_IDLE;
      rx_tick_q   <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rxd_meta_q  <= uart_rxd;
      rxd_sync_q  <= rxd_meta_q;
      rx_wr_q     <= rx_wr_d;
      rx_rd_q     <= rx_rd_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_state_q  <= rx_state_d;
      rx_tick_q   <= rx_tick_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign uart_txd     = txd_q;
  assign bus.tx_full  = tx_full_q;
  assign bus.rx_valid = (rx_cnt_q != '0);
  assign bus.rx_data  = bus.rx_valid ? rx_mem[rx_rd_q] : 8'h00;
  assign rx_overrun   = overrun_q;
  assign frame_err    = frame_err_q;
endmodule

// File: doc/citadel_uart.md
Name: citadel_uart

Overview:
- Serial front end for the Citadel SoC's byte IO port; sits directly downstream of the core's memory-mapped tx path and upstream of its rx path.
- Buffers bytes written by the core in a TX FIFO and serializes them as 8N1 on uart_txd.
- Deserializes uart_rxd into an RX FIFO whose head is presented to the core's rx/rx_ready/rx_ack interface.
- Lets software drive a real UART without stalling on bit timing.

Parameters:
- CLKS_PER_BIT, 104: r_clk cycles per serial bit. Must be >= 4.
- FIFO_DEPTH, 16: entries per FIFO. Must be a power of two, >= 2.

Ports:
- r_clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- tx_data  in  8  byte from core (core's tx)
- tx_strobe  in  1  one-cycle push pulse (core's tx_ready)
- tx_full  out  1  TX FIFO full
- rx_data  out  8  RX FIFO head (to core's rx)
- rx_valid  out  1  RX FIFO non-empty (to core's rx_ready)
- rx_ack  in  1  one-cycle pop pulse (core's rx_ack)
- uart_txd  out  1  serial out; idle high
- uart_rxd  in  1  serial in; asynchronous to r_clk
- rx_overrun  out  1  sticky: received byte dropped, RX FIFO full
- frame_err  out  1  sticky: stop bit sampled low

Behaviour:
- Reset, asynchronous on rst_n low:
  - uart_txd=1, tx_full=0, rx_valid=0, rx_data=0, rx_overrun=0, frame_err=0.
  - Both FIFOs empty; both FSMs in IDLE.
  - rxd synchronizer flops reset to 1.
  - A frame in progress is abandoned; uart_txd returns high immediately.
- TX FIFO push:
  - tx_strobe high at a rising edge pushes tx_data if not full.
  - Push while full drops the byte; no flag is raised.
  - tx_full is registered and reflects count==FIFO_DEPTH after the edge.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE->START when FIFO is non-empty: pop head into shift register, uart_txd<=0.
  - START->DATA after CLKS_PER_BIT cycles; bits sent LSB first, each held exactly CLKS_PER_BIT cycles.
  - DATA->STOP after bit 7; uart_txd=1 for CLKS_PER_BIT cycles.
  - STOP->START directly if the FIFO is non-empty (no idle gap), else STOP->IDLE.
  - Latency: strobe sampled at edge E0 into an empty FIFO with TX idle -> uart_txd low from edge E0+2.
  - Frame is 10*CLKS_PER_BIT cycles.
- RX input: uart_rxd passes through a 2-flop synchronizer. All RX logic uses the synchronized value s.
- RX FSM, states IDLE, START, DATA, STOP, WAIT_HIGH:
  - IDLE->START when s==0; counter loads CLKS_PER_BIT/2 (integer divide).
  - In START, at mid-bit: s==1 -> IDLE (glitch, nothing recorded); else -> DATA.
  - In DATA, sample every CLKS_PER_BIT cycles; 8 samples, LSB first.
  - STOP samples at mid stop bit:
    - s==1: push byte, then -> IDLE.
    - s==0: set frame_err, discard byte, -> WAIT_HIGH.
  - WAIT_HIGH -> IDLE when s==1.
- RX FIFO:
  - rx_data is the combinational head; rx_valid = !empty, registered count.
  - rx_ack high at an edge with rx_valid=1 pops one entry; rx_ack with rx_valid=0 is ignored.
  - rx_data stays stable until popped.
  - Push while full and no pop in the same cycle drops the byte and sets rx_overrun.
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overrun.
  - Push and pop in the same cycle while empty is impossible (pop requires rx_valid).
- Pointers: log2(FIFO_DEPTH) bits, wrap naturally; count is one bit wider.
- Sticky flags: rx_overrun and frame_err clear only on reset.

Test Plan:
- CLKS_PER_BIT=4, reset released, tx_strobe with tx_data=0x55 -> uart_txd low from edge E0+2; bit pattern 0,1,0,1,0,1,0,1,0,1 (start, LSB..MSB, stop), each 4 cycles; then idle high.
- Push 0xA5,0x3C on consecutive cycles -> two frames back-to-back (80 cycles total, no gap); tx_full never set. Push FIFO_DEPTH+2 bytes with TX busy -> tx_full=1, 2 bytes dropped, exactly FIFO_DEPTH+1 frames emitted (one already in shift register).
- Drive 8N1 0xC3 on uart_rxd at CLKS_PER_BIT=4 -> rx_valid=1, rx_data=0xC3. Pulse rx_ack -> rx_valid=0 next cycle. rx_ack while empty -> no change.
- 2-cycle low glitch on uart_rxd -> no byte, no flags. Frame 0x81 with stop bit driven low -> frame_err=1, no push; FSM waits for line high, then next good frame 0x12 is received.
- Receive FIFO_DEPTH+1 bytes without ack -> first FIFO_DEPTH bytes kept in order, rx_overrun=1. Repeat with rx_ack on the same edge as the final push -> no overrun, count stays FIFO_DEPTH.
- Assert rst_n low mid-TX-frame and mid-RX-frame -> uart_txd=1 immediately, all outputs at reset values; after release the next 0x7E transmits and receives correctly.
